// File: rtl/sensor_frame_tx.sv
// sensor_frame_tx: sensor frame encoder and UART 8N1 transmitter (clk_uart domain).
//
// On an accepted request it snapshots acceleration/direction and sends an 11-byte
// frame LSB first: HEADER, FRAME_TYPE, accel lo/hi, dir lo/hi, four zero bytes,
// then the 8-bit sum of bytes 0..9. The bytes go out back-to-back.
//
// Ports:
//   clk_uart      in   UART-domain clock
//   rst           in   synchronous active-high reset
//   acceleration  in   [15:0] payload word 0, sampled on accept
//   direction     in   [15:0] payload word 1, sampled on accept
//   send          in   level-sampled send request
//   ready         out  1 = idle or finishing; a send this cycle is accepted
//   frame_done    out  one-cycle pulse after the last stop bit
//   txd           out  serial output, idle high
//
// Optional feature: define SENSOR_FRAME_TX_AUTO_EN to add a free-running request
// every AUTO_PERIOD cycles, ORed with send. A request that fires while busy is dropped.
module sensor_frame_tx #(
`ifdef SENSOR_FRAME_TX_AUTO_EN
  parameter int unsigned AUTO_PERIOD  = 200000,
`endif
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'h55,
  parameter logic [7:0]  FRAME_TYPE   = 8'h51
) (
  input  logic        clk_uart,
  input  logic        rst,
  input  logic [15:0] acceleration,
  input  logic [15:0] direction,
  input  logic        send,
  output logic        ready,
  output logic        frame_done,
  output logic        txd
);

  localparam int unsigned   CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LastByte = 4'd10;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       payload_q, payload_d;
  logic [7:0]        cur_byte;
  logic              req;
  logic              tick;

`ifdef SENSOR_FRAME_TX_AUTO_EN
  localparam int unsigned AutoW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AutoW-1:0] auto_cnt_q;
  logic             auto_fire;

  assign auto_fire = (auto_cnt_q == AutoW'(AUTO_PERIOD - 1));

  // Free-running; never paused by a busy transmitter.
  always_ff @(posedge clk_uart) begin
    if (rst) begin
      auto_cnt_q <= '0;
    end else if (auto_fire) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_q + 1'b1;
    end
  end

  assign req = send | auto_fire;
`else
  assign req = send;
`endif

  assign tick = (bit_cnt_q == CntMax);

  // Byte under transmission; the last byte is the running sum of the first ten.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = FRAME_TYPE;
      4'd2:    cur_byte = payload_q[7:0];
      4'd3:    cur_byte = payload_q[15:8];
      4'd4:    cur_byte = payload_q[23:16];
      4'd5:    cur_byte = payload_q[31:24];
      4'd10:   cur_byte = csum_q;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d     = csum_q;
    payload_d  = payload_q;
    txd        = 1'b1;
    ready      = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        ready      = 1'b1;
        frame_done = (state_q == StDone);
        state_d    = StIdle;
        if (req) begin
          payload_d  = {direction, acceleration};
          byte_idx_d = '0;
          bit_idx_d  = '0;
          bit_cnt_d  = '0;
          csum_d     = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StData: begin
        txd = cur_byte[bit_idx_q];
        if (tick) begin
          bit_cnt_d = '0;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StStop: begin
        txd = 1'b1;
        if (tick) begin
          bit_cnt_d = '0;
          // Carry out of bit 7 is discarded by the 8-bit add.
          csum_d    = csum_q + cur_byte;
          if (byte_idx_q == LastByte) begin
            state_d = StDone;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = StStart;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      payload_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q     <= csum_d;
      payload_q  <= payload_d;
    end
  end

endmodule

// File: tb/tb_sensor_frame_tx.sv
module tb_sensor_frame_tx;

  localparam int CPB      = 4;
  localparam int FRAME_CY = 110 * CPB;

  logic        clk_uart = 1'b0;
  logic        rst;
  logic [15:0] acceleration;
  logic [15:0] direction;
  logic        send;
  logic        ready;
  logic        frame_done;
  logic        txd;

  int errors = 0;
  int checks = 0;

  sensor_frame_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_uart    (clk_uart),
    .rst         (rst),
    .acceleration(acceleration),
    .direction   (direction),
    .send        (send),
    .ready       (ready),
    .frame_done  (frame_done),
    .txd         (txd)
  );

  always #5 clk_uart = ~clk_uart;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_uart);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int         cyc      = 0;
  bit         chk_on   = 0;
  bit         fs_valid = 0;
  int         fs       = 0;
  logic [7:0] m_bytes [11];

  function automatic void model_load(input logic [15:0] a, input logic [15:0] d);
    int sum;
    m_bytes[0] = 8'h55;
    m_bytes[1] = 8'h51;
    m_bytes[2] = a[7:0];
    m_bytes[3] = a[15:8];
    m_bytes[4] = d[7:0];
    m_bytes[5] = d[15:8];
    for (int k = 6; k < 10; k++) m_bytes[k] = 8'h00;
    sum = 0;
    for (int k = 0; k < 10; k++) sum += int'(m_bytes[k]);
    m_bytes[10] = 8'((sum % 256));
  endfunction

  // Line level at offset o from the first start bit: 10 bit-slots per byte.
  function automatic logic model_txd(input int o);
    int k;
    int p;
    logic [7:0] b;
    k = o / (10 * CPB);
    p = (o % (10 * CPB)) / CPB;
    b = m_bytes[k];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  // ---------------- UART monitor state ----------------
  logic [7:0] rx_q [$];
  int         rx_st_q [$];
  int         done_q [$];
  bit         rx_busy = 0;
  int         rx_st = 0;
  logic [7:0] rx_sh;

  always @(negedge clk_uart) begin
    logic e_txd, e_ready, e_done;
    bit   active;
    int   o;

    active  = fs_valid && cyc >= fs && cyc < fs + FRAME_CY;
    e_done  = fs_valid && cyc == fs + FRAME_CY;
    e_ready = !active;
    e_txd   = active ? model_txd(cyc - fs) : 1'b1;

    if (chk_on) begin
      checks++;
      if (txd !== e_txd || ready !== e_ready || frame_done !== e_done) begin
        errors++;
        $display("FAIL cycle %0d: txd/ready/done got %b%b%b expected %b%b%b",
                 cyc, txd, ready, frame_done, e_txd, e_ready, e_done);
      end
      if (frame_done === 1'b1) done_q.push_back(cyc);
    end

    // UART decoder, independent of the model.
    if (rst) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (chk_on && txd === 1'b0) begin
        rx_busy = 1;
        rx_st   = cyc;
      end
    end else begin
      o = cyc - rx_st;
      if (o >= CPB && o < 9 * CPB && (o % CPB) == CPB / 2) rx_sh[o / CPB - 1] = txd;
      if (o == 9 * CPB + CPB / 2) begin
        check("stop bit", int'(txd), 1);
        rx_q.push_back(rx_sh);
        rx_st_q.push_back(rx_st);
      end
      if (o == 10 * CPB - 1) rx_busy = 0;
    end

    // Model update for the coming edge.
    if (rst) begin
      fs_valid = 0;
      chk_on   = 1;
    end else if (send && e_ready) begin
      fs       = cyc + 1;
      fs_valid = 1;
      model_load(acceleration, direction);
    end
    cyc++;
  end

  task automatic clear_mon();
    rx_q.delete();
    rx_st_q.delete();
    done_q.delete();
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] d);
    clear_mon();
    acceleration = a;
    direction    = d;
    send         = 1'b1;
    tick(1);
    send = 1'b0;
    tick(FRAME_CY + 10);
  endtask

  logic [7:0] exp1 [11];

  initial begin
    rst          = 1'b1;
    send         = 1'b0;
    acceleration = '0;
    direction    = '0;
    tick(3);
    rst = 1'b0;
    check("reset ready", int'(ready), 1);
    check("reset txd", int'(txd), 1);
    check("reset frame_done", int'(frame_done), 0);
    tick(5);

    // Single frame with hand-computed bytes.
    exp1 = '{8'h55, 8'h51, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64};
    run_frame(16'h1234, 16'hABCD);
    check("t1 byte count", rx_q.size(), 11);
    if (rx_q.size() == 11)
      for (int i = 0; i < 11; i++) check($sformatf("t1 byte %0d", i), int'(rx_q[i]), int'(exp1[i]));
    check("t1 done count", done_q.size(), 1);
    if (done_q.size() == 1 && rx_st_q.size() > 0)
      check("t1 done latency", done_q[0] - rx_st_q[0], 440);

    // Checksum boundaries.
    run_frame(16'h0000, 16'h0000);
    check("zero byte count", rx_q.size(), 11);
    if (rx_q.size() == 11) check("zero checksum", int'(rx_q[10]), 'hA6);
    run_frame(16'hFFFF, 16'hFFFF);
    check("ones byte count", rx_q.size(), 11);
    if (rx_q.size() == 11) begin
      check("ones b2", int'(rx_q[2]), 'hFF);
      check("ones checksum", int'(rx_q[10]), 'hA2);
    end

    // Send held high, inputs changing mid-frame.
    clear_mon();
    acceleration = 16'h0A0B;
    direction    = 16'h0C0D;
    send         = 1'b1;
    tick(1);
    for (int i = 0; i < FRAME_CY; i++) begin
      if (i % 7 == 6) begin
        acceleration = acceleration + 16'h1111;
        direction    = direction + 16'h0101;
      end
      tick(1);
    end
    tick(1);
    send = 1'b0;
    tick(FRAME_CY + 10);
    check("busy byte count", rx_q.size(), 22);
    if (rx_q.size() == 22) begin
      check("busy b2", int'(rx_q[2]), 'h0B);
      check("busy b3", int'(rx_q[3]), 'h0A);
      check("busy b4", int'(rx_q[4]), 'h0D);
      check("busy b5", int'(rx_q[5]), 'h0C);
      check("busy checksum", int'(rx_q[10]), 'hD4);
    end
    check("busy done count", done_q.size(), 2);
    if (done_q.size() == 2 && rx_st_q.size() == 22)
      check("back-to-back start", rx_st_q[11] - done_q[0], 1);

    // Reset during DATA of byte 4.
    clear_mon();
    acceleration = 16'h1111;
    direction    = 16'h2222;
    send         = 1'b1;
    tick(1);
    send = 1'b0;
    tick(170);
    rst = 1'b1;
    tick(1);
    check("midrst ready", int'(ready), 1);
    check("midrst txd", int'(txd), 1);
    rst = 1'b0;
    tick(20);
    check("midrst no done", done_q.size(), 0);
    run_frame(16'h5678, 16'h9ABC);
    check("post-rst byte count", rx_q.size(), 11);
    if (rx_q.size() == 11) begin
      check("post-rst b0", int'(rx_q[0]), 'h55);
      check("post-rst b2", int'(rx_q[2]), 'h78);
      check("post-rst b5", int'(rx_q[5]), 'h9A);
      check("post-rst checksum", int'(rx_q[10]), 'hCA);
    end
    check("post-rst done count", done_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
